// File: rtl/md_issue_stage_pkg.sv
// Shared multiply/divide opcode and funct constants, plus the E-stage payload type.
package md_issue_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
  } e_stage_t;

endpackage

// File: rtl/md_issue_stage_if.sv
// D-stage inputs, E-stage payload and stall status of the md issue stage.
interface md_issue_stage_if;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_rs_data;
  logic [31:0] d_rt_data;
  logic        md_busy;
  logic        flush;
  logic        e_valid;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  logic [31:0] e_data1;
  logic [31:0] e_data2;
  logic        stall;
  logic [31:0] stall_cnt;

  modport master (
    output d_valid, d_instr, d_pc, d_rs_data, d_rt_data, md_busy, flush,
    input  e_valid, e_instr, e_pc, e_data1, e_data2, stall, stall_cnt
  );

  modport slave (
    input  d_valid, d_instr, d_pc, d_rs_data, d_rt_data, md_busy, flush,
    output e_valid, e_instr, e_pc, e_data1, e_data2, stall, stall_cnt
  );
endinterface

// File: rtl/md_class_decode.sv
// Combinational md-class / start-class classifier for one instruction slot.
module md_class_decode
  import md_issue_stage_pkg::*;
(
  input  logic       valid_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       md_o,
  output logic       start_o
);
  logic special;

  assign special = valid_i && (op_i == OP_SPECIAL);

  always_comb begin
    md_o    = 1'b0;
    start_o = 1'b0;
    if (special) begin
      unique case (funct_i)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
          md_o    = 1'b1;
          start_o = 1'b1;
        end
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: md_o = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/md_issue_stage.sv
// D->E issue register that holds back md instructions while the mul/div unit is busy.
// Optional stall-cycle counter enabled by MD_STALL_CNT_EN.
module md_issue_stage
  import md_issue_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  md_issue_stage_if.slave  md_if
);
  e_stage_t e_q, e_d;
  logic     d_md, d_start, e_md, e_start;

  md_class_decode u_dec_d (
    .valid_i (md_if.d_valid),
    .op_i    (md_if.d_instr[31:26]),
    .funct_i (md_if.d_instr[5:0]),
    .md_o    (d_md),
    .start_o (d_start)
  );

  md_class_decode u_dec_e (
    .valid_i (e_q.valid),
    .op_i    (e_q.instr[31:26]),
    .funct_i (e_q.instr[5:0]),
    .md_o    (e_md),
    .start_o (e_start)
  );

  // A start sitting in E has not raised md_busy yet, so it must also block.
  assign md_if.stall = d_md && (md_if.md_busy || e_start);

  always_comb begin
    e_d = '0;
    if (!md_if.flush && !md_if.stall) begin
      e_d.valid = md_if.d_valid;
      e_d.instr = md_if.d_instr;
      e_d.pc    = md_if.d_pc;
      e_d.data1 = md_if.d_rs_data;
      e_d.data2 = md_if.d_rt_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= '0;
    else        e_q <= e_d;
  end

  assign md_if.e_valid = e_q.valid;
  assign md_if.e_instr = e_q.instr;
  assign md_if.e_pc    = e_q.pc;
  assign md_if.e_data1 = e_q.data1;
  assign md_if.e_data2 = e_q.data2;

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (md_if.stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign md_if.stall_cnt = stall_cnt_q;
`else
  assign md_if.stall_cnt = '0;
`endif

  logic unused_e_md;
  assign unused_e_md = e_md;
endmodule
